prbs8_checker: RTL and testbench

Receive-side companion to the 8-bit maximal-length LFSR pattern generator (taps q[7]^q[5]^q[4]^q[3], seed 8'd1). It accepts the generator's 8-bit output words, self-synchronises to the sequence, and then predicts every following word. It reports lock status, per-word error pulses and saturating error and sample counters. It sits at the far end of a link or datapath under test, fed by the generator's q/en pair.

---
 rtl/prbs_pkg.sv | 20 ++
 rtl/prbs8_checker.sv | 147 ++++++++++++++
 tb/tb_prbs8_checker.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the 8-bit PRBS generator and checker.
// The tap polynomial lives here so both ends always agree.
package prbs_pkg;

    localparam int PRBS_W = 8;
    localparam logic [PRBS_W-1:0] PRBS_SEED = 8'd1;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } chk_state_e;

    function automatic logic [PRBS_W-1:0] prbs8_next(
        input logic [PRBS_W-1:0] x
    );
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

endpackage

// File: rtl/prbs8_checker.sv
// Self-synchronising checker for the 8-bit PRBS pattern stream.
// Once locked, the prediction free-runs so one bad word costs one error.
module prbs8_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [PRBS_W-1:0] din,
    input  logic              clr,
    output logic              locked,
    output logic              err,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  sample_count,
    output logic              zero_seen
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    chk_state_e        state_q, state_d;
    logic [PRBS_W-1:0] exp_q, exp_d;
    logic [GW-1:0]     good_q, good_d;
    logic [BW-1:0]     bad_q, bad_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d;
    logic [CNT_W-1:0]  scnt_q, scnt_d;
    logic              zero_q, zero_d;

    logic          match;
    logic          is_zero;
    logic [GW-1:0] good_inc;
    logic [BW-1:0] bad_inc;

    assign match    = (din == exp_q);
    assign is_zero  = (din == '0);
    assign good_inc = good_q + GW'(1);
    assign bad_inc  = bad_q + BW'(1);

    // Sync FSM: hunt for a seed, verify predictions, then track.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_d   = 1'b0;
        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (!is_zero) begin
                        exp_d   = prbs8_next(din);
                        good_d  = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_zero) begin
                        state_d = HUNT;
                    end else if (match) begin
                        exp_d  = prbs8_next(din);
                        good_d = good_inc;
                        if (good_inc == GW'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        exp_d  = prbs8_next(din);
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    exp_d = prbs8_next(exp_q);
                    if (match) begin
                        bad_d = '0;
                    end else begin
                        err_d = 1'b1;
                        bad_d = bad_inc;
                        if (bad_inc == BW'(UNLOCK_CNT)) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Status and saturating counters; clr wins over increment and set.
    always_comb begin
        locked_d = (state_d == LOCKED);
        ecnt_d   = ecnt_q;
        scnt_d   = scnt_q;
        zero_d   = zero_q;
        if (clr) begin
            ecnt_d = '0;
            scnt_d = '0;
            zero_d = 1'b0;
        end else begin
            if (err_d && (ecnt_q != '1)) begin
                ecnt_d = ecnt_q + CNT_W'(1);
            end
            if (en && (state_q == LOCKED) && (scnt_q != '1)) begin
                scnt_d = scnt_q + CNT_W'(1);
            end
            if (en && is_zero) begin
                zero_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= HUNT;
            exp_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            ecnt_q   <= '0;
            scnt_q   <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            ecnt_q   <= ecnt_d;
            scnt_q   <= scnt_d;
            zero_q   <= zero_d;
        end
    end

    assign locked       = locked_q;
    assign err          = err_q;
    assign err_count    = ecnt_q;
    assign sample_count = scnt_q;
    assign zero_seen    = zero_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Scoreboard bench for prbs8_checker: default instance plus a
// small-counter instance (CNT_W=4, UNLOCK_CNT=8) for saturation.
module tb_prbs8_checker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = 8'h00;

    logic        l0, e0, z0;
    logic [15:0] ec0, sc0;
    logic        l1, e1, z1;
    logic [3:0]  ec1, sc1;

    always #5 clk = ~clk;

    prbs8_checker u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .din(din), .clr(clr),
        .locked(l0), .err(e0), .err_count(ec0),
        .sample_count(sc0), .zero_seen(z0)
    );

    prbs8_checker #(
        .LOCK_CNT(4), .UNLOCK_CNT(8), .CNT_W(4)
    ) u_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .din(din), .clr(clr),
        .locked(l1), .err(e1), .err_count(ec1),
        .sample_count(sc1), .zero_seen(z1)
    );

    typedef struct packed {
        logic        sat;
        logic        l;
        logic        e;
        logic [15:0] ec;
        logic [15:0] sc;
        logic        z;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rst_req = 0;
    int   step_no = 0;
    logic sel = 1'b0;
    logic done = 1'b0;

    function automatic logic [7:0] nxt(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic int sat4(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    task automatic cmp(input string nm, input logic [15:0] act,
                       input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation per driven cycle, checks resets.
    initial begin : monitor
        exp_t        x;
        logic        al, ae, az;
        logic [15:0] aec, asc;
        int          rst_seen;
        int          idx;
        rst_seen = 0;
        idx = 0;
        forever begin
            @(posedge clk or rst_req or posedge done);
            if (done) begin
                n_cmp++;
                if (q.size() != 0) begin
                    n_bad++;
                    $display("FAIL leftover actual=%0d required=0",
                             q.size());
                end
                break;
            end else if (rst_req != rst_seen) begin
                rst_seen = rst_req;
                cmp("rst_locked", 16'(l0), 16'h0);
                cmp("rst_err", 16'(e0), 16'h0);
                cmp("rst_errcnt", ec0, 16'h0);
                cmp("rst_smpcnt", sc0, 16'h0);
                cmp("rst_zero", 16'(z0), 16'h0);
                cmp("rst_sat_locked", 16'(l1), 16'h0);
                cmp("rst_sat_errcnt", 16'(ec1), 16'h0);
                cmp("rst_sat_smpcnt", 16'(sc1), 16'h0);
            end else begin
                #1;
                if (q.size() > 0) begin
                    x = q.pop_front();
                    idx++;
                    if (x.sat) begin
                        al = l1; ae = e1; az = z1;
                        aec = 16'(ec1); asc = 16'(sc1);
                    end else begin
                        al = l0; ae = e0; az = z0;
                        aec = ec0; asc = sc0;
                    end
                    n_cmp++;
                    if ({al, ae, aec, asc, az} !==
                        {x.l, x.e, x.ec, x.sc, x.z}) begin
                        n_bad++;
                        $display("FAIL step%0d actual l=%b e=%b ec=%0d sc=%0d z=%b required l=%b e=%b ec=%0d sc=%0d z=%b",
                                 idx, al, ae, aec, asc, az,
                                 x.l, x.e, x.ec, x.sc, x.z);
                    end
                end
            end
        end
    end

    task automatic step(input logic e_, input logic [7:0] d,
                        input logic c, input logic l, input logic er,
                        input int ec, input int sc, input logic z);
        exp_t x;
        @(negedge clk);
        en = e_; din = d; clr = c;
        x.sat = sel; x.l = l; x.e = er;
        x.ec = 16'(ec); x.sc = 16'(sc); x.z = z;
        q.push_back(x);
        step_no++;
    endtask

    // Asynchronous reset away from any clock edge, checked at once.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0; en = 1'b0; clr = 1'b0;
        #1;
        rst_req++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : driver
        logic [7:0] w, d;
        int   ne, ns;
        logic zz, bad;

        do_reset();
        // Lock on 01..11, then track.
        step(1, 8'h01, 0, 0, 0, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0, 0, 0, 0);
        step(1, 8'h04, 0, 0, 0, 0, 0, 0);
        step(1, 8'h08, 0, 0, 0, 0, 0, 0);
        step(1, 8'h11, 0, 1, 0, 0, 0, 0);
        step(1, 8'h23, 0, 1, 0, 0, 1, 0);
        step(1, 8'h47, 0, 1, 0, 0, 2, 0);
        // Single corrupted word costs one error.
        step(1, 8'h8E, 0, 1, 0, 0, 3, 0);
        step(1, 8'h1D, 0, 1, 1, 1, 4, 0);
        step(1, 8'h38, 0, 1, 0, 1, 5, 0);
        step(1, 8'h71, 0, 1, 0, 1, 6, 0);
        // Four mismatches drop lock.
        step(1, 8'hFF, 0, 1, 1, 2, 7, 0);
        step(1, 8'hFF, 0, 1, 1, 3, 8, 0);
        step(1, 8'hFF, 0, 1, 1, 4, 9, 0);
        step(1, 8'hFF, 0, 0, 1, 5, 10, 0);
        step(0, 8'h00, 0, 0, 0, 5, 10, 0);
        // Relock needs seed plus four matches.
        step(1, 8'h25, 0, 0, 0, 5, 10, 0);
        step(1, 8'h4B, 0, 0, 0, 5, 10, 0);
        step(1, 8'h97, 0, 0, 0, 5, 10, 0);
        step(1, 8'h2E, 0, 0, 0, 5, 10, 0);
        step(1, 8'h5C, 0, 1, 0, 5, 10, 0);

        // Zero word in HUNT, then clr behaviour.
        do_reset();
        step(1, 8'h00, 0, 0, 0, 0, 0, 1);
        step(1, 8'h00, 0, 0, 0, 0, 0, 1);
        step(1, 8'h01, 0, 0, 0, 0, 0, 1);
        step(1, 8'h02, 0, 0, 0, 0, 0, 1);
        step(1, 8'h04, 0, 0, 0, 0, 0, 1);
        step(1, 8'h08, 0, 0, 0, 0, 0, 1);
        step(1, 8'h11, 0, 1, 0, 0, 0, 1);
        step(1, 8'h23, 0, 1, 0, 0, 1, 1);
        step(1, 8'h47, 1, 1, 0, 0, 0, 0);
        step(1, 8'h00, 1, 1, 1, 0, 0, 0);
        step(1, 8'h1C, 0, 1, 0, 0, 1, 0);

        // Idle gaps are transparent.
        for (int i = 0; i < 10; i++) step(0, 8'hA5, 0, 1, 0, 0, 1, 0);
        step(1, 8'h38, 0, 1, 0, 0, 2, 0);
        for (int i = 0; i < 10; i++) step(0, 8'h5A, 0, 1, 0, 0, 2, 0);
        step(1, 8'h71, 0, 1, 0, 0, 3, 0);
        step(1, 8'hFF, 0, 1, 1, 1, 4, 0);
        // Reset mid-lock, reseed in VERIFY, full relock.
        do_reset();
        step(1, 8'hE2, 0, 0, 0, 0, 0, 0);
        step(1, 8'hC4, 0, 0, 0, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0, 0, 0, 0);
        step(1, 8'h66, 0, 0, 0, 0, 0, 0);
        step(1, 8'hCD, 0, 0, 0, 0, 0, 0);
        step(1, 8'h9A, 0, 0, 0, 0, 0, 0);
        step(1, 8'h35, 0, 1, 0, 0, 0, 0);

        // Saturation on the 4-bit instance.
        do_reset();
        sel = 1'b1;
        step(1, 8'h01, 0, 0, 0, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0, 0, 0, 0);
        step(1, 8'h04, 0, 0, 0, 0, 0, 0);
        step(1, 8'h08, 0, 0, 0, 0, 0, 0);
        step(1, 8'h11, 0, 1, 0, 0, 0, 0);
        w = 8'h23; ne = 0; ns = 0; zz = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bad = (i % 2 == 0);
            d = bad ? (w ^ 8'h01) : w;
            if (bad) ne++;
            ns++;
            if (d == 8'h00) zz = 1'b1;
            step(1, d, 0, 1, bad, sat4(ne), sat4(ns), zz);
            w = nxt(w);
        end
        step(1, w ^ 8'h01, 1, 1, 1, 0, 0, 0);
        w = nxt(w);
        step(1, w, 0, 1, 0, 0, 1, 0);

        @(negedge clk);
        en = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        done = 1'b1;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
